serial_adder_ctrl: RTL and testbench

- Bit-serial addition controller that time-shares one `full_adder` instance over a WIDTH-bit operand pair.
- It latches both operands on a start handshake and sequences one bit per clock, LSB first, through the shared `full_adder`.
- The carry is held in a flip-flop between bits.
- It presents the sum, carry-out and signed overflow with a one-cycle done pulse.
- It is the area-minimal adder option for multi-bit datapaths in the class designs.

---
 rtl/serial_adder_ctrl.sv | 119 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full_adder processes a WIDTH-bit operand pair
// LSB first, one bit per clock, with the carry held in a flip-flop between bits.
`timescale 1ns/1ps

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_MSB  = CW'(WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Only the upper WIDTH-1 bits of the sum shift register are ever consumed,
  // so the discarded LSB is not stored.
  logic [WIDTH-2:0] sum_hi;
  logic [WIDTH-1:0] sum_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             msb_cin;
  logic             fa_sum;
  logic             fa_carry;

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_carry)
  );

  assign sum_next = {fa_sum, sum_hi};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      cnt      <= '0;
      carry    <= 1'b0;
      msb_cin  <= 1'b0;
      a_sr     <= '0;
      b_sr     <= '0;
      sum_hi   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            carry  <= cin;
            cnt    <= '0;
            sum_hi <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          sum_hi <= sum_next[WIDTH-1:1];
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= fa_carry;
          cnt    <= cnt + CW'(1);
          if (cnt == CNT_MSB) msb_cin <= fa_carry;
          if (cnt == CNT_LAST) begin
            sum      <= sum_next;
            cout     <= fa_carry;
            overflow <= msb_cin ^ fa_carry;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8): vector table plus corner sequences.
`timescale 1ns/1ps

module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vecs[7];

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues one start, returns edges from the accepting edge until done is seen.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        output int lat, output logic busy0);
    @(negedge clk);
    a = ta; b = tb; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy0 = busy;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic b0;
    int last_done;
    int pulses;
    logic seen;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};

    // Reset state
    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_sum", {24'd0, sum}, 32'd0);
    check("reset_cout", {31'd0, cout}, 32'd0);
    check("reset_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, lat, b0);
      check($sformatf("v%0d_busy", i), {31'd0, b0}, 32'd1);
      check($sformatf("v%0d_latency", i), lat, W);
      check($sformatf("v%0d_sum", i), {24'd0, sum}, {24'd0, vecs[i].s});
      check($sformatf("v%0d_cout", i), {31'd0, cout}, {31'd0, vecs[i].co});
      check($sformatf("v%0d_ovf", i), {31'd0, overflow}, {31'd0, vecs[i].ov});
      check($sformatf("v%0d_busy_at_done", i), {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_width", i), {31'd0, done}, 32'd0);
    end

    // Results hold through idle
    repeat (5) @(posedge clk);
    #1;
    check("hold_sum", {24'd0, sum}, 32'h46);

    // Start during RUN is ignored; operands toggling during RUN have no effect
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    repeat (2) begin @(posedge clk); #1; lat++; end
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(posedge clk); #1; lat++;
    start = 1'b0;
    while (!done && lat < 20) begin
      a = ~a; b = b ^ 8'h5A;
      @(posedge clk); #1;
      lat++;
    end
    check("ign_latency", lat, W);
    check("ign_sum", {24'd0, sum}, 32'h30);
    check("ign_cout", {31'd0, cout}, 32'd0);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    check("ign_no_second_op", {31'd0, seen}, 32'd0);

    // start held high: back-to-back operations every W+1 cycles
    @(negedge clk);
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    last_done = -1;
    pulses = 0;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        check($sformatf("b2b_sum_%0d", pulses), {24'd0, sum}, 32'h03);
        if (last_done >= 0) check($sformatf("b2b_period_%0d", pulses), t - last_done, W + 1);
        last_done = t;
      end
    end
    check("b2b_pulse_count", pulses, 4);
    start = 1'b0;
    repeat (12) @(posedge clk);

    // Asynchronous reset mid-RUN
    @(negedge clk);
    a = 8'h55; b = 8'h11; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_sum", {24'd0, sum}, 32'd0);
    check("arst_cout", {31'd0, cout}, 32'd0);
    check("arst_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    check("arst_no_done", {31'd0, seen}, 32'd0);
    run_op(8'h7F, 8'h01, 1'b0, lat, b0);
    check("post_rst_latency", lat, W);
    check("post_rst_sum", {24'd0, sum}, 32'h80);
    check("post_rst_ovf", {31'd0, overflow}, 32'd1);
    check("post_rst_cout", {31'd0, cout}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
